// File: rtl/noise_pkg.sv
// Shared definitions for the noise generator CDF table loader.
package noise_pkg;

  // Number of CDF entries written per load when not overridden.
  localparam int ENTRIES_DEFAULT = 128;

  // Loader FSM states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GET_LO    = 3'd1,
    GET_HI    = 3'd2,
    WRITE     = 3'd3,
    WAIT_DONE = 3'd4,
    DONE      = 3'd5,
    ERROR     = 3'd6
  } state_e;

  // Status codes reported on err_code.
  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_ORDER   = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_ABORT   = 2'b11
  } err_code_e;

endpackage

// File: rtl/noise_table_loader.sv
// Streams 64-bit CDF entries from a 32-bit host interface into the noise
// generator table, checking monotonic order and waiting for the generator
// to report that its table is ready.
module noise_table_loader
  import noise_pkg::*;
#(
  parameter int ENTRIES     = ENTRIES_DEFAULT,
  parameter int HOLD_CYCLES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] cfg_data,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  output logic [63:0] mem_data,
  output logic [7:0]  location,
  output logic        load_mem,
  input  logic        done_wait,
  output logic        busy,
  output logic        loaded,
  output logic        err,
  output logic [1:0]  err_code
);

  // Index needs one extra code so that the value ENTRIES is representable.
  localparam int IDX_W  = $clog2(ENTRIES + 1);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IDX_W-1:0]  ENTRIES_L = IDX_W'(ENTRIES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  index_q, index_d;
  logic [31:0]       entryLo_q, entryLo_d;
  logic [63:0]       memData_q, memData_d;
  logic [63:0]       prev_q, prev_d;
  logic [7:0]        location_q, location_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              loaded_q, loaded_d;
  logic [1:0]        errCode_q, errCode_d;

  logic [63:0]       assembled;
  logic [IDX_W-1:0]  idxNext;
  logic              orderBad;
  logic              holdLast;
  logic              timerLast;
  logic              moreEntries;

  // Shared decode: the full entry on the high-word transfer, the order test
  // against the previously written entry, and the counter end conditions.
  always_comb begin
    assembled   = {cfg_data, entryLo_q};
    idxNext     = index_q + 1'b1;
    orderBad    = (index_q != '0) && (assembled < prev_q);
    holdLast    = (hold_q == HOLD_LAST);
    timerLast   = (timer_q == TMR_LAST);
    moreEntries = (idxNext < ENTRIES_L);
  end

  // State register; reset wins over everything, including a write in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A start pulse during word collection aborts the load;
  // during WRITE and WAIT_DONE it is ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) state_d = GET_LO;
      end
      GET_LO: begin
        if (start)          state_d = ERROR;
        else if (cfg_valid) state_d = GET_HI;
      end
      GET_HI: begin
        if (start)          state_d = ERROR;
        else if (cfg_valid) state_d = orderBad ? ERROR : WRITE;
      end
      WRITE: begin
        if (holdLast) state_d = moreEntries ? GET_LO : WAIT_DONE;
      end
      WAIT_DONE: begin
        if (done_wait)      state_d = DONE;
        else if (timerLast) state_d = ERROR;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded purely from the current state.
  always_comb begin
    cfg_ready = (state_q == GET_LO) || (state_q == GET_HI);
    load_mem  = (state_q == WRITE);
    busy      = (state_q != IDLE) && (state_q != DONE) && (state_q != ERROR);
    err       = (state_q == ERROR);
  end

  // Datapath next values: word capture, write window timing, index and
  // previous-entry tracking, timeout counting and status codes.
  always_comb begin
    index_d    = index_q;
    entryLo_d  = entryLo_q;
    memData_d  = memData_q;
    prev_d     = prev_q;
    location_d = location_q;
    hold_d     = hold_q;
    timer_d    = timer_q;
    loaded_d   = loaded_q;
    errCode_d  = errCode_q;
    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          index_d   = '0;
          prev_d    = '0;
          hold_d    = '0;
          timer_d   = '0;
          loaded_d  = 1'b0;
          errCode_d = ERR_NONE;
        end
      end
      GET_LO: begin
        if (start) begin
          errCode_d = ERR_ABORT;
        end else if (cfg_valid) begin
          entryLo_d = cfg_data;
        end
      end
      GET_HI: begin
        if (start) begin
          errCode_d = ERR_ABORT;
        end else if (cfg_valid) begin
          if (orderBad) begin
            errCode_d = ERR_ORDER;
          end else begin
            memData_d  = assembled;
            location_d = 8'(index_q);
            hold_d     = '0;
          end
        end
      end
      WRITE: begin
        if (holdLast) begin
          hold_d  = '0;
          prev_d  = memData_q;
          index_d = idxNext;
          timer_d = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (done_wait) begin
          loaded_d = 1'b1;
        end else if (timerLast) begin
          errCode_d = ERR_TIMEOUT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        errCode_d = errCode_q;
      end
    endcase
  end

  // Datapath registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      index_q    <= '0;
      entryLo_q  <= '0;
      memData_q  <= '0;
      prev_q     <= '0;
      location_q <= '0;
      hold_q     <= '0;
      timer_q    <= '0;
      loaded_q   <= 1'b0;
      errCode_q  <= ERR_NONE;
    end else begin
      index_q    <= index_d;
      entryLo_q  <= entryLo_d;
      memData_q  <= memData_d;
      prev_q     <= prev_d;
      location_q <= location_d;
      hold_q     <= hold_d;
      timer_q    <= timer_d;
      loaded_q   <= loaded_d;
      errCode_q  <= errCode_d;
    end
  end

  assign mem_data = memData_q;
  assign location = location_q;
  assign loaded   = loaded_q;
  assign err_code = errCode_q;

endmodule

// File: tb/tb_noise_table_loader.sv
// Scoreboard bench for noise_table_loader: the driver pushes the expected
// table writes as it streams entries, and a monitor checks every load_mem
// cycle against the front of the queue.
module tb_noise_table_loader;

  localparam int ENTRIES = 128;
  localparam int HOLD    = 2;
  localparam int TMO     = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [63:0] mem_data;
  logic [7:0]  location;
  logic        load_mem;
  logic        done_wait;
  logic        busy;
  logic        loaded;
  logic        err;
  logic [1:0]  err_code;

  typedef struct {
    logic [7:0]  loc;
    logic [63:0] data;
  } exp_t;

  exp_t expQ[$];
  int   holdCnt    = 0;
  int   loadCount  = 0;
  int   checkCount = 0;
  int   passCount  = 0;

  noise_table_loader #(
    .ENTRIES(ENTRIES),
    .HOLD_CYCLES(HOLD),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .cfg_data(cfg_data),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .mem_data(mem_data),
    .location(location),
    .load_mem(load_mem),
    .done_wait(done_wait),
    .busy(busy),
    .loaded(loaded),
    .err(err),
    .err_code(err_code)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // An expired wait bound counts as a failed comparison.
  task automatic boundFail(input string name);
    checkCount++;
    $display("[TB] FAIL %s: wait bound expired", name);
  endtask

  // Monitor: every load_mem cycle must match the oldest expected write, and
  // each write must last exactly HOLD cycles before the next one starts.
  always @(negedge clk) begin
    if (!rst && load_mem) begin
      loadCount++;
      if (expQ.size() == 0) begin
        boundFail("unexpected_load_mem");
      end else begin
        checkOutput("mon_mem_data", mem_data, expQ[0].data);
        checkOutput("mon_location", 64'(location), 64'(expQ[0].loc));
        holdCnt++;
        if (holdCnt == HOLD) begin
          void'(expQ.pop_front());
          holdCnt = 0;
        end
      end
    end
  end

  // Safety net so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL global_watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // One-cycle start pulse; returns 1 time unit after the sampling edge.
  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one host word until it transfers; optionally throttle cfg_valid.
  task automatic applyStimulus(input logic [31:0] w, input bit throttle);
    bit   done = 0;
    bit   r;
    bit   v;
    int   guard = 0;
    while (!done) begin
      cfg_data  = w;
      cfg_valid = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
      v = cfg_valid;
      @(negedge clk);
      r = cfg_ready;
      @(posedge clk); #1;
      if (r && v) done = 1;
      guard++;
      if (!done && guard > 300) begin
        boundFail("word_transfer");
        done = 1;
      end
    end
    cfg_valid = 1'b0;
  endtask

  // Send one 64-bit entry low word first; expected write queued if it is legal.
  task automatic sendEntry(input logic [63:0] val, input int idx, input bit throttle, input bit expectWrite);
    applyStimulus(val[31:0], throttle);
    if (expectWrite) expQ.push_back('{loc: 8'(idx), data: val});
    applyStimulus(val[63:32], throttle);
  endtask

  // Wait until the final write window has closed.
  task automatic waitLoadLow();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (load_mem && guard < 20);
    if (load_mem) boundFail("load_mem_fall");
  endtask

  // Full load of i*2^56 entries; with giveDone, done_wait rises 3 cycles
  // after the last write and the loaded status is checked.
  task automatic fullLoad(input bit throttle, input bit giveDone);
    int guard = 0;
    loadCount = 0;
    pulseStart();
    checkOutput("load_busy", 64'(busy), 64'd1);
    checkOutput("load_cfg_ready", 64'(cfg_ready), 64'd1);
    for (int i = 0; i < ENTRIES; i++) begin
      sendEntry(64'(i) << 56, i, throttle, 1'b1);
    end
    waitLoadLow();
    if (giveDone) begin
      repeat (3) @(posedge clk);
      #1 done_wait = 1'b1;
      while (!loaded && guard < 50) begin
        @(posedge clk); #1;
        guard++;
      end
      if (!loaded) boundFail("loaded_wait");
      done_wait = 1'b0;
      checkOutput("done_loaded", 64'(loaded), 64'd1);
      checkOutput("done_err", 64'(err), 64'd0);
      checkOutput("done_busy", 64'(busy), 64'd0);
      checkOutput("done_load_cycles", 64'(loadCount), 64'(ENTRIES * HOLD));
      checkOutput("done_queue_empty", 64'(expQ.size()), 64'd0);
      checkOutput("done_location_held", 64'(location), 64'd127);
      checkOutput("done_mem_data_held", mem_data, 64'd127 << 56);
    end
  endtask

  initial begin
    int k;
    rst       = 1'b1;
    start     = 1'b0;
    cfg_data  = '0;
    cfg_valid = 1'b0;
    done_wait = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_load_mem", 64'(load_mem), 64'd0);
    checkOutput("rst_cfg_ready", 64'(cfg_ready), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_loaded", 64'(loaded), 64'd0);
    checkOutput("rst_err", 64'(err), 64'd0);
    checkOutput("rst_err_code", 64'(err_code), 64'd0);
    checkOutput("rst_mem_data", mem_data, 64'd0);
    checkOutput("rst_location", 64'(location), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] full load");
    fullLoad(1'b0, 1'b1);

    $display("[TB] ordering error at entry 5");
    loadCount = 0;
    pulseStart();
    for (int i = 0; i < 5; i++) sendEntry(64'(i) << 40, i, 1'b0, 1'b1);
    sendEntry(64'd3 << 40, 5, 1'b0, 1'b0);
    checkOutput("order_err", 64'(err), 64'd1);
    checkOutput("order_err_code", 64'(err_code), 64'd1);
    checkOutput("order_cfg_ready", 64'(cfg_ready), 64'd0);
    checkOutput("order_busy", 64'(busy), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("order_load_cycles", 64'(loadCount), 64'(5 * HOLD));
    checkOutput("order_location_held", 64'(location), 64'd4);
    checkOutput("order_queue_empty", 64'(expQ.size()), 64'd0);

    $display("[TB] timeout with done_wait low");
    fullLoad(1'b0, 1'b0);
    k = 0;
    while (!err && k < 2 * TMO) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("timeout_cycles", 64'(k), 64'(TMO));
    checkOutput("timeout_err_code", 64'(err_code), 64'd2);
    checkOutput("timeout_loaded", 64'(loaded), 64'd0);
    checkOutput("timeout_load_cycles", 64'(loadCount), 64'(ENTRIES * HOLD));

    $display("[TB] throttled load");
    fullLoad(1'b1, 1'b1);

    $display("[TB] reset during write at index 40");
    pulseStart();
    for (int i = 0; i < 41; i++) sendEntry(64'(i) << 56, i, 1'b0, 1'b1);
    checkOutput("midwrite_load_mem", 64'(load_mem), 64'd1);
    checkOutput("midwrite_location", 64'(location), 64'd40);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_mid_load_mem", 64'(load_mem), 64'd0);
    checkOutput("rst_mid_location", 64'(location), 64'd0);
    checkOutput("rst_mid_mem_data", mem_data, 64'd0);
    checkOutput("rst_mid_busy", 64'(busy), 64'd0);
    checkOutput("rst_mid_cfg_ready", 64'(cfg_ready), 64'd0);
    expQ.delete();
    holdCnt = 0;
    rst = 1'b0;
    @(posedge clk); #1;
    fullLoad(1'b0, 1'b1);

    $display("[TB] abort during GET_HI");
    pulseStart();
    for (int i = 0; i < 3; i++) sendEntry(64'(i) << 56, i, 1'b0, 1'b1);
    applyStimulus(32'h0, 1'b0);
    pulseStart();
    checkOutput("abort_err", 64'(err), 64'd1);
    checkOutput("abort_err_code", 64'(err_code), 64'd3);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_cfg_ready", 64'(cfg_ready), 64'd0);
    checkOutput("abort_queue_empty", 64'(expQ.size()), 64'd0);
    fullLoad(1'b0, 1'b1);
    checkOutput("final_err_code", 64'(err_code), 64'd0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
